// File: rtl/vga_axi_rd_arbiter_if.sv
// AR/R signal bundle between the two display-side read requesters, the
// read arbiter and the downstream AXI4 read slave.
interface vga_axi_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  logic              s0_arvalid, s1_arvalid;
  logic              s0_arready, s1_arready;
  logic [ADDR_W-1:0] s0_araddr,  s1_araddr;
  logic [ID_W-1:0]   s0_arid,    s1_arid;
  logic [7:0]        s0_arlen,   s1_arlen;
  logic [2:0]        s0_arsize,  s1_arsize;
  logic [1:0]        s0_arburst, s1_arburst;

  logic              s0_rvalid,  s1_rvalid;
  logic              s0_rready,  s1_rready;
  logic [DATA_W-1:0] s0_rdata,   s1_rdata;
  logic [1:0]        s0_rresp,   s1_rresp;
  logic              s0_rlast,   s1_rlast;
  logic [ID_W-1:0]   s0_rid,     s1_rid;

  logic              m_arvalid;
  logic              m_arready;
  logic [ADDR_W-1:0] m_araddr;
  logic [ID_W-1:0]   m_arid;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;

  logic              m_rvalid;
  logic              m_rready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic [ID_W-1:0]   m_rid;

  // Arbiter view
  modport slave (
    input  s0_arvalid, s1_arvalid, s0_araddr, s1_araddr, s0_arid, s1_arid,
           s0_arlen, s1_arlen, s0_arsize, s1_arsize, s0_arburst, s1_arburst,
           s0_rready, s1_rready,
           m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
    output s0_arready, s1_arready,
           s0_rvalid, s1_rvalid, s0_rdata, s1_rdata, s0_rresp, s1_rresp,
           s0_rlast, s1_rlast, s0_rid, s1_rid,
           m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst, m_rready
  );

  // Environment view: requesters plus downstream slave
  modport master (
    output s0_arvalid, s1_arvalid, s0_araddr, s1_araddr, s0_arid, s1_arid,
           s0_arlen, s1_arlen, s0_arsize, s1_arsize, s0_arburst, s1_arburst,
           s0_rready, s1_rready,
           m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
    input  s0_arready, s1_arready,
           s0_rvalid, s1_rvalid, s0_rdata, s1_rdata, s0_rresp, s1_rresp,
           s0_rlast, s1_rlast, s0_rid, s1_rid,
           m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst, m_rready
  );
endinterface

// File: rtl/vga_axi_rd_arbiter.sv
// Two-requester AXI4 read arbiter, one burst outstanding, VGA fetch (req0) has priority.
// Optional anti-starvation for req1 is enabled by defining VGA_ARB_STARVE_EN.
module vga_axi_rd_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 64,
  parameter int ID_W         = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clock,
  input  logic                resetn,
  vga_axi_rd_arbiter_if.slave bus,
  output logic                owner,
  output logic                busy,
  output logic                len_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state_q, state_d;
  logic              grant_vld, grant_sel, ar_hs, r_beat;
  logic              owner_q, len_err_q;
  logic [8:0]        beat_cnt_q;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [ID_W-1:0]   ar_id_q;
  logic [7:0]        ar_len_q;
  logic [2:0]        ar_size_q;
  logic [1:0]        ar_burst_q;

  assign grant_vld = bus.s0_arvalid | bus.s1_arvalid;
  assign ar_hs     = (state_q == IDLE) & grant_vld;
  assign r_beat    = (state_q == DATA) & bus.m_rvalid & bus.m_rready;

`ifdef VGA_ARB_STARVE_EN
  logic [2:0] starve_q;

  // req1 only overrides req0 once req0 has won STARVE_LIMIT contested grants in a row
  assign grant_sel = bus.s1_arvalid &
                     (~bus.s0_arvalid | (starve_q == 3'(STARVE_LIMIT)));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      starve_q <= 3'd0;
    end else if (ar_hs) begin
      if (grant_sel || !bus.s1_arvalid) starve_q <= 3'd0;
      else if (starve_q != 3'd7)        starve_q <= starve_q + 3'd1;
    end
  end
`else
  logic [31:0] unused_starve_limit;

  assign unused_starve_limit = 32'(STARVE_LIMIT);
  assign grant_sel           = ~bus.s0_arvalid & bus.s1_arvalid;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      owner_q    <= 1'b0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      if (ar_hs) begin
        ar_addr_q  <= grant_sel ? bus.s1_araddr  : bus.s0_araddr;
        ar_id_q    <= grant_sel ? bus.s1_arid    : bus.s0_arid;
        ar_len_q   <= grant_sel ? bus.s1_arlen   : bus.s0_arlen;
        ar_size_q  <= grant_sel ? bus.s1_arsize  : bus.s0_arsize;
        ar_burst_q <= grant_sel ? bus.s1_arburst : bus.s0_arburst;
        owner_q    <= grant_sel;
        beat_cnt_q <= '0;
      end else if (r_beat) begin
        beat_cnt_q <= beat_cnt_q + 9'd1;
        // Counter holds beats already taken, so the last beat must see arlen
        if (bus.m_rlast && (beat_cnt_q != {1'b0, ar_len_q})) len_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.s0_arready = 1'b0;
    bus.s1_arready = 1'b0;
    bus.m_arvalid  = 1'b0;
    bus.m_rready   = 1'b0;
    bus.s0_rvalid  = 1'b0;
    bus.s1_rvalid  = 1'b0;
    bus.s0_rdata   = '0;
    bus.s1_rdata   = '0;
    bus.s0_rresp   = '0;
    bus.s1_rresp   = '0;
    bus.s0_rlast   = 1'b0;
    bus.s1_rlast   = 1'b0;
    bus.s0_rid     = '0;
    bus.s1_rid     = '0;
    case (state_q)
      IDLE: begin
        bus.s0_arready = grant_vld & ~grant_sel;
        bus.s1_arready = grant_vld &  grant_sel;
        if (grant_vld) state_d = ADDR;
      end
      ADDR: begin
        bus.m_arvalid = 1'b1;
        if (bus.m_arready) state_d = DATA;
      end
      DATA: begin
        if (owner_q) begin
          bus.m_rready  = bus.s1_rready;
          bus.s1_rvalid = bus.m_rvalid;
          bus.s1_rdata  = bus.m_rdata;
          bus.s1_rresp  = bus.m_rresp;
          bus.s1_rlast  = bus.m_rlast;
          bus.s1_rid    = bus.m_rid;
        end else begin
          bus.m_rready  = bus.s0_rready;
          bus.s0_rvalid = bus.m_rvalid;
          bus.s0_rdata  = bus.m_rdata;
          bus.s0_rresp  = bus.m_rresp;
          bus.s0_rlast  = bus.m_rlast;
          bus.s0_rid    = bus.m_rid;
        end
        if (bus.m_rvalid && bus.m_rready && bus.m_rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.m_araddr  = ar_addr_q;
  assign bus.m_arid    = ar_id_q;
  assign bus.m_arlen   = ar_len_q;
  assign bus.m_arsize  = ar_size_q;
  assign bus.m_arburst = ar_burst_q;
  assign owner         = owner_q;
  assign busy          = (state_q != IDLE);
  assign len_err       = len_err_q;

endmodule

// File: doc/vga_axi_rd_arbiter.md
Name: vga_axi_rd_arbiter

Overview:
- Shares the single AXI4 read master port of the SoC display subsystem between two requesters.
  - Requester 0: the VGA line-fetch engine (200-beat, 64-bit INCR bursts). It is latency-critical and has priority.
  - Requester 1: a secondary reader (blitter/DMA).
- Only one burst is outstanding at a time. The AR channel is registered, the R channel is routed to the owner, and a beat counter checks burst length.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, data width
- ID_W, 4, AXI ID width
- STARVE_LIMIT, 4, consecutive req0 grants allowed while req1 waits (only used with the optional feature)

Ports:
- clock  input  1  single clock domain
- resetn  input  1  asynchronous active-low reset
- s0_arvalid, s1_arvalid  input  1 each  requester AR valid
- s0_arready, s1_arready  output  1 each  requester AR ready
- s0_araddr, s1_araddr  input  ADDR_W each  read address
- s0_arid, s1_arid  input  ID_W each  read ID
- s0_arlen, s1_arlen  input  8 each  beats minus 1
- s0_arsize, s1_arsize  input  3 each  beat size
- s0_arburst, s1_arburst  input  2 each  burst type
- s0_rvalid, s1_rvalid  output  1 each  routed R valid
- s0_rready, s1_rready  input  1 each  requester R ready
- s0_rdata, s1_rdata  output  DATA_W each  routed read data
- s0_rresp, s1_rresp  output  2 each  routed response
- s0_rlast, s1_rlast  output  1 each  routed last
- s0_rid, s1_rid  output  ID_W each  routed ID
- m_arvalid  output  1  master AR valid
- m_arready  input  1  master AR ready
- m_araddr / m_arid / m_arlen / m_arsize / m_arburst  output  ADDR_W / ID_W / 8 / 3 / 2  registered AR fields
- m_rvalid  input  1  master R valid
- m_rready  output  1  master R ready
- m_rdata / m_rresp / m_rlast / m_rid  input  DATA_W / 2 / 1 / ID_W  master R channel
- owner  output  1  current/last granted requester
- busy  output  1  high when state is not IDLE
- len_err  output  1  one-cycle pulse on burst length mismatch

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE; m_arvalid=0, m_rready=0, all s*_arready=0, all s*_rvalid=0, owner=0, len_err=0, beat counter=0, m_ar* registers=0.
- Reset mid-burst abandons the burst; the downstream slave is reset in the same domain.
- States: IDLE, ADDR, DATA.
- IDLE:
  - Grant is combinational. If s0_arvalid, grant 0; else if s1_arvalid, grant 1.
  - s*_arready is high only for the granted requester, only in IDLE. The handshake completes in that cycle.
  - On handshake: latch the granted AR fields into m_ar*, set owner, clear the beat counter, go to ADDR.
  - Latency: requester handshake in cycle N gives m_arvalid=1 in cycle N+1.
- ADDR:
  - m_arvalid=1 with stable fields. Both s*_arready=0.
  - On m_arready: go to DATA; m_arvalid=0 next cycle.
- DATA:
  - Combinational routing to the owner only: s[owner]_rvalid=m_rvalid; m_rready=s[owner]_rready; rdata/rresp/rlast/rid passed through.
  - Non-owner rvalid=0. Non-owner rdata/rresp/rlast/rid are driven 0.
  - Beat counter (9-bit) increments on each m_rvalid&m_rready.
  - On the beat with m_rlast: if counter != latched arlen, pulse len_err for one cycle. Either way go to IDLE.
  - The next grant can occur in the cycle after rlast; there are no bubble-free back-to-back bursts.
- m_rvalid outside DATA is ignored: m_rready=0 and nothing is routed.
- Non-owner arvalid may stay asserted during a burst; it is held off without being dropped.
- busy = (state != IDLE).
- The block never alters any AR or R field value.

Optional Feature:
- Macro VGA_ARB_STARVE_EN.
- Defined:
  - A 3-bit saturating counter increments on each req0 grant made while s1_arvalid=1. It clears on any req1 grant, and when req0 is granted with s1_arvalid=0.
  - When the counter equals STARVE_LIMIT, req1 wins the next simultaneous request.
- Undefined: strict fixed priority for req0; the counter logic is absent.

Test Plan:
- Single req0 burst: araddr=0x8000_0000, arlen=199, m_arready high at the first m_arvalid cycle, 200 beats with rlast on beat 200 -> s0 receives 200 beats, len_err=0, busy falls the cycle after rlast, s1_rvalid stays 0.
- Simultaneous s0/s1 arvalid in IDLE -> s0_arready=1 and s1_arready=0. After s0's burst completes, s1 is granted on the first IDLE cycle; m_araddr equals s1_araddr.
- Backpressure: m_arready held low 5 cycles -> m_arvalid held with stable fields. s0_rready toggling 1,0,1 -> m_rready mirrors it and the beat count is correct.
- Length error: arlen=3, slave asserts rlast on beat 2 -> len_err pulses exactly one cycle, state returns to IDLE.
- Async reset asserted in DATA mid-burst -> all valids/readys drop to 0 immediately. After release, a new s1 request is granted normally.
- With VGA_ARB_STARVE_EN and STARVE_LIMIT=4, both requesters continuously valid -> grant order 0,0,0,0,1,0,0,0,0,1. Without the macro -> all grants to 0.
